// File: rtl/item_dispense_ctrl.sv
// Purchase controller between a request source and the item price/count memory.
// Reads one item, decides OK/SOLD_OUT/INSUFFICIENT/INVALID, and on OK decrements the count and dispenses.
module item_dispense_ctrl #(
  parameter  int MAX_ITEMS = 1024,
  localparam int AW        = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [AW-1:0] req_item,
  input  logic [15:0]   req_credit,
  output logic          req_ready,
  output logic [AW-1:0] mem_raddr,
  input  logic [15:0]   mem_rd_price,
  input  logic [7:0]    mem_rd_count,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [15:0]   mem_wprice,
  output logic [7:0]    mem_wcount,
  output logic          resp_valid,
  output logic [1:0]    resp_status,
  output logic [15:0]   resp_change,
  output logic          dispense_valid,
  output logic [AW-1:0] dispense_item
);

  localparam logic [1:0] ST_OK           = 2'd0;
  localparam logic [1:0] ST_SOLD_OUT     = 2'd1;
  localparam logic [1:0] ST_INSUFFICIENT = 2'd2;
  localparam logic [1:0] ST_INVALID      = 2'd3;

  typedef enum logic [1:0] {IDLE, READ, CHECK, COMMIT} state_t;

  state_t        state, state_n;
  logic [AW-1:0] item_q;
  logic [15:0]   credit_q;
  logic [1:0]    status_q;
  logic [15:0]   change_q;
  logic [15:0]   wprice_q;
  logic [7:0]    wcount_q;
  logic [1:0]    status_c;

  // Priority INVALID > SOLD_OUT > INSUFFICIENT > OK.
  function automatic logic [1:0] eval_status(input logic [AW-1:0] item,
                                             input logic [15:0]   credit,
                                             input logic [15:0]   price,
                                             input logic [7:0]    count);
    if (32'(item) >= 32'(MAX_ITEMS)) return ST_INVALID;
    else if (count == 8'd0)          return ST_SOLD_OUT;
    else if (credit < price)         return ST_INSUFFICIENT;
    else                             return ST_OK;
  endfunction

  // OK returns the difference; every refusal refunds the full credit.
  function automatic logic [15:0] eval_change(input logic [1:0]  status,
                                              input logic [15:0] credit,
                                              input logic [15:0] price);
    return (status == ST_OK) ? (credit - price) : credit;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = READ;
      READ:    state_n = CHECK;
      CHECK:   state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign status_c = eval_status(item_q, credit_q, mem_rd_price, mem_rd_count);

  // Request capture in IDLE, decision capture in CHECK (read data valid here)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      item_q   <= '0;
      credit_q <= '0;
      status_q <= ST_OK;
      change_q <= '0;
      wprice_q <= '0;
      wcount_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        item_q   <= req_item;
        credit_q <= req_credit;
      end
      if (state == CHECK) begin
        status_q <= status_c;
        change_q <= eval_change(status_c, credit_q, mem_rd_price);
        wprice_q <= mem_rd_price;
        wcount_q <= mem_rd_count - 8'd1;
      end
    end
  end

  // Pulses decode from state so reset clears them without waiting for a clock.
  assign req_ready      = (state == IDLE);
  assign mem_raddr      = item_q;
  assign resp_valid     = (state == COMMIT);
  assign resp_status    = status_q;
  assign resp_change    = change_q;
  assign mem_we         = (state == COMMIT) && (status_q == ST_OK);
  assign mem_waddr      = item_q;
  assign mem_wprice     = wprice_q;
  assign mem_wcount     = wcount_q;
  assign dispense_valid = (state == COMMIT) && (status_q == ST_OK);
  assign dispense_item  = item_q;

endmodule
